// File: rtl/rtc_pkg.sv
// Shared limits, field widths and load-FSM encoding for the RTC timekeeper.
package rtc_pkg;
    localparam int HR_W = 5;
    localparam int MS_W = 6;

    localparam logic [MS_W-1:0] SEC_MAX = MS_W'(59);
    localparam logic [MS_W-1:0] MIN_MAX = MS_W'(59);
    localparam logic [HR_W-1:0] HR_MAX  = HR_W'(23);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } load_st_e;
endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-second advance strobe.
module rtc_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Strobe is combinational so the time registers advance on the same edge
    // that registers the external tick pulse.
    assign tick = en && (r_cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/rtc_timekeeper.sv
// Hour/minute/second timekeeper with validated load handshake, 12/24h display
// conversion and a latched alarm.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode24,
    input  logic            set_valid,
    output logic            set_ready,
    input  logic [HR_W-1:0] set_hh,
    input  logic [MS_W-1:0] set_mm,
    input  logic [MS_W-1:0] set_ss,
    output logic            set_done,
    output logic            set_err,
    input  logic            alarm_on,
    input  logic [HR_W-1:0] alarm_hh,
    input  logic [MS_W-1:0] alarm_mm,
    input  logic            alarm_ack,
    output logic [HR_W-1:0] hh,
    output logic [MS_W-1:0] mm,
    output logic [MS_W-1:0] ss,
    output logic            pm,
    output logic            tick,
    output logic            alarm
);
    load_st_e        r_st;
    logic [HR_W-1:0] r_cap_hh, r_hours;
    logic [MS_W-1:0] r_cap_mm, r_cap_ss, r_min, r_sec;
    logic            r_tick, r_done, r_err;

    logic            w_tick, w_load_ok, w_sec_wrap, w_min_wrap;
    logic [HR_W-1:0] w_hr_nxt, w_h12;
    logic [MS_W-1:0] w_min_nxt, w_sec_nxt;

    rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (w_load_ok),
        .tick  (w_tick)
    );

    assign w_load_ok = (r_st == APPLY) && (r_cap_hh <= HR_MAX) &&
                       (r_cap_mm <= MIN_MAX) && (r_cap_ss <= SEC_MAX);

    // Full carry chain resolves in one cycle.
    always_comb begin
        w_sec_wrap = (r_sec == SEC_MAX);
        w_min_wrap = (r_min == MIN_MAX);
        w_sec_nxt  = w_sec_wrap ? '0 : r_sec + MS_W'(1);
        w_min_nxt  = r_min;
        w_hr_nxt   = r_hours;
        if (w_sec_wrap) begin
            w_min_nxt = w_min_wrap ? '0 : r_min + MS_W'(1);
            if (w_min_wrap)
                w_hr_nxt = (r_hours == HR_MAX) ? '0 : r_hours + HR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hours <= '0;
            r_min   <= '0;
            r_sec   <= '0;
        end else if (w_load_ok) begin
            r_hours <= r_cap_hh;
            r_min   <= r_cap_mm;
            r_sec   <= r_cap_ss;
        end else if (w_tick) begin
            r_hours <= w_hr_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= IDLE;
            r_cap_hh <= '0;
            r_cap_mm <= '0;
            r_cap_ss <= '0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_done <= w_load_ok;
            r_err  <= (r_st == APPLY) && !w_load_ok;
            case (r_st)
                IDLE: if (set_valid) begin
                    r_cap_hh <= set_hh;
                    r_cap_mm <= set_mm;
                    r_cap_ss <= set_ss;
                    r_st     <= APPLY;
                end
                default: r_st <= IDLE;
            endcase
        end
    end

    generate
        if (ALARM_EN) begin : g_alarm
            logic r_alarm;
            logic w_hit;

            // Only a tick advance can land on the alarm time; loads never fire it.
            assign w_hit = alarm_on && w_tick && !w_load_ok && (w_hr_nxt == alarm_hh) &&
                           (w_min_nxt == alarm_mm) && (w_sec_nxt == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_alarm <= 1'b0;
                else if (alarm_ack || !alarm_on)
                    r_alarm <= 1'b0;
                else if (w_hit)
                    r_alarm <= 1'b1;
            end
            assign alarm = r_alarm;
        end else begin : g_no_alarm
            assign alarm = 1'b0;
        end
    endgenerate

    assign w_h12     = (r_hours >= HR_W'(12)) ? r_hours - HR_W'(12) : r_hours;
    assign hh        = mode24 ? r_hours : ((w_h12 == '0) ? HR_W'(12) : w_h12);
    assign pm        = (r_hours >= HR_W'(12));
    assign mm        = r_min;
    assign ss        = r_sec;
    assign tick      = r_tick;
    assign set_ready = (r_st == IDLE);
    assign set_done  = r_done;
    assign set_err   = r_err;
endmodule
